// File: rtl/bin_div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package bin_div_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultW = 8;

endpackage

// File: rtl/bin_div_seq_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted remainder,
// restoring the shifted value when the subtraction borrows.
module bin_div_seq_div_step #(
    parameter int unsigned W = 8
) (
    input  logic [W:0]   r_shift,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         q_bit
);

    logic [W:0] nb;
    logic [W:0] g;
    logic [W:0] p;
    logic [W:0] c;
    logic [W:0] diff;

    // Subtraction as r_shift + ~divisor + 1, carries formed from generate/propagate terms.
    always_comb begin
        nb   = ~{1'b0, divisor};
        g    = r_shift & nb;
        p    = r_shift ^ nb;
        c    = '0;
        c[0] = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        diff   = p ^ c;
        q_bit  = ~diff[W];
        r_next = q_bit ? diff : r_shift;
    end

endmodule

// File: rtl/bin_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with start/done handshake.
module bin_div_seq
    import bin_div_seq_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         dz
);

    localparam int unsigned CW = $clog2(W + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dz_q, dz_d;

    logic [W:0]    r_shift;
    logic [W:0]    r_next;
    logic          q_bit;
    logic          unused_r_msb;

    // The partial remainder stays below the divisor, so its stored form needs only W bits.
    assign r_shift      = {r_q, q_q[W-1]};
    assign unused_r_msb = r_next[W];

    bin_div_seq_div_step #(
        .W (W)
    ) u_step (
        .r_shift (r_shift),
        .divisor (dvs_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (divisor == '0) ? StDone : StRun;
            StRun:   if (cnt_q == CW'(1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        quotient  = quo_q;
        remainder = rem_q;
        dz        = dz_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        r_d   = r_q;
        q_d   = q_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dz_d  = dz_q;
        if (state_q == StIdle && start) begin
            dvs_d = divisor;
            dz_d  = 1'b0;
            if (divisor == '0) begin
                quo_d = '1;
                rem_d = dividend;
                dz_d  = 1'b1;
            end else begin
                r_d   = '0;
                q_d   = dividend;
                cnt_d = CW'(W);
            end
        end else if (state_q == StRun) begin
            r_d   = r_next[W-1:0];
            q_d   = {q_q[W-2:0], q_bit};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                quo_d = {q_q[W-2:0], q_bit};
                rem_d = r_next[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            r_q   <= '0;
            q_q   <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            r_q   <= r_d;
            q_q   <= q_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dz_q  <= dz_d;
        end
    end

endmodule
